// File: rtl/grid_scanner.sv
// LED-matrix row scanner: IDLE -> LOAD -> SHOW (DWELL cycles) -> BLANK per row, with a frame pulse on the last row.
// Optional macro GRID_SCANNER_SNAPSHOT_EN adds a frame snapshot register for tear-free frames.
module grid_scanner #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned COLS  = 16,
  parameter int unsigned DWELL = 1000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic [ROWS*COLS-1:0]     i_grid,
  output logic [ROWS-1:0]          o_row_drive,
  output logic [COLS-1:0]          o_col_drive,
  output logic [$clog2(ROWS)-1:0]  o_row_index,
  output logic                     o_frame_pulse
);

  localparam int unsigned IDX_W = $clog2(ROWS);
  localparam int unsigned DW_W  = $clog2(DWELL + 1);
  localparam int unsigned GRID_W = ROWS * COLS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHOW,
    S_BLANK
  } state_t;

  state_t             r_state;
  logic [ROWS-1:0]    r_row_drive;
  logic [COLS-1:0]    r_col_drive;
  logic [IDX_W-1:0]   r_row_idx;
  logic [DW_W-1:0]    r_dwell;
  logic               r_frame_pulse;

  state_t             w_state;
  logic [ROWS-1:0]    w_row_drive;
  logic [COLS-1:0]    w_col_drive;
  logic [IDX_W-1:0]   w_row_idx;
  logic [DW_W-1:0]    w_dwell;
  logic               w_frame_pulse;

  logic [GRID_W-1:0]  w_src;
  logic [COLS-1:0]    w_src_row;

`ifdef GRID_SCANNER_SNAPSHOT_EN
  logic [GRID_W-1:0]  r_snap;

  // Capture a whole generation at scan start and at each frame boundary
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_snap <= '0;
    end else if ((r_state == S_IDLE && i_enable) || r_frame_pulse) begin
      r_snap <= i_grid;
    end
  end

  assign w_src = r_snap;
`else
  assign w_src = i_grid;
`endif

  assign w_src_row = COLS'(w_src >> (32'(r_row_idx) * COLS));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_row_drive   <= '0;
      r_col_drive   <= '0;
      r_row_idx     <= '0;
      r_dwell       <= '0;
      r_frame_pulse <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_row_drive   <= w_row_drive;
      r_col_drive   <= w_col_drive;
      r_row_idx     <= w_row_idx;
      r_dwell       <= w_dwell;
      r_frame_pulse <= w_frame_pulse;
    end
  end

  // Next-state and next-output values; outputs are registered with the state
  always_comb begin
    w_state       = r_state;
    w_row_drive   = '0;
    w_col_drive   = r_col_drive;
    w_row_idx     = r_row_idx;
    w_dwell       = '0;
    w_frame_pulse = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_col_drive = '0;
        w_row_idx   = '0;
        if (i_enable) begin
          w_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_col_drive = w_src_row;
        w_row_drive = ROWS'(1) << r_row_idx;
        w_state     = S_SHOW;
      end
      S_SHOW: begin
        if (r_dwell == DW_W'(DWELL - 1)) begin
          w_state       = S_BLANK;
          w_frame_pulse = (r_row_idx == IDX_W'(ROWS - 1));
        end else begin
          w_row_drive = r_row_drive;
          w_dwell     = r_dwell + DW_W'(1);
        end
      end
      S_BLANK: begin
        w_state   = S_LOAD;
        w_row_idx = (r_row_idx == IDX_W'(ROWS - 1)) ? '0 : r_row_idx + IDX_W'(1);
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Dropping enable abandons the frame without a pulse
    if (!i_enable && r_state != S_IDLE) begin
      w_state       = S_IDLE;
      w_row_drive   = '0;
      w_col_drive   = '0;
      w_row_idx     = '0;
      w_dwell       = '0;
      w_frame_pulse = 1'b0;
    end
  end

  assign o_row_drive   = r_row_drive;
  assign o_col_drive   = r_col_drive;
  assign o_row_index   = r_row_idx;
  assign o_frame_pulse = r_frame_pulse;

endmodule

// File: tb/tb_grid_scanner.sv
// Bench for grid_scanner (4x4, DWELL=3): time-indexed scan model plus hand-computed spot checks.
module tb_grid_scanner;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned DWELL = 3;
  localparam int          P     = DWELL + 2;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [ROWS*COLS-1:0] grid;
  logic [ROWS-1:0]      row_drive;
  logic [COLS-1:0]      col_drive;
  logic [1:0]           row_index;
  logic                 frame_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  grid_scanner #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (en),
    .i_grid        (grid),
    .o_row_drive   (row_drive),
    .o_col_drive   (col_drive),
    .o_row_index   (row_index),
    .o_frame_pulse (frame_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: p counts cycles since the scan started; row/phase follow from p
  bit                   m_run;
  int                   m_p;
  logic [COLS-1:0]      m_col;
  logic [ROWS*COLS-1:0] m_snap;

  function automatic logic [COLS-1:0] row_of(input logic [ROWS*COLS-1:0] g, input int r);
    logic [ROWS*COLS-1:0] t;
    t = g >> (r * COLS);
    return t[COLS-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int np;
    logic [ROWS*COLS-1:0] src;
    if (!rst_n) begin
      m_run <= 1'b0; m_p <= 0; m_col <= '0; m_snap <= '0;
    end else if (!en) begin
      m_run <= 1'b0; m_p <= 0; m_col <= '0;
    end else if (!m_run) begin
      m_run <= 1'b1; m_p <= 0; m_snap <= grid;
    end else begin
      np = m_p + 1;
      m_p <= np;
`ifdef GRID_SCANNER_SNAPSHOT_EN
      src = m_snap;
`else
      src = grid;
`endif
      if (np % P == 0 && (np / P) % ROWS == 0) m_snap <= grid;
      if (np % P == 1) m_col <= row_of(src, (np / P) % ROWS);
    end
  end

  always @(negedge clk) begin
    int k, r;
    k = m_p % P;
    r = (m_p / P) % ROWS;
    chk("row_drive", int'(row_drive), (m_run && k >= 1 && k <= DWELL) ? (1 << r) : 0);
    chk("col_drive", int'(col_drive), m_run ? int'(m_col) : 0);
    chk("row_index", int'(row_index), m_run ? r : 0);
    chk("frame_pulse", int'(frame_pulse), (m_run && k == DWELL + 1 && r == ROWS - 1) ? 1 : 0);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pulses;
    bit hit;
    rst_n = 1'b0; en = 1'b1; grid = 16'hFFFF;
    step(3);
    chk("reset_rd", int'(row_drive), 0);
    chk("reset_cd", int'(col_drive), 0);
    chk("reset_fp", int'(frame_pulse), 0);
    grid = 16'h8421;
    step(1);
    rst_n = 1'b1;

    // First edge enters LOAD, second edge shows row 0
    step(1);
    chk("first_load_rd", int'(row_drive), 0);
    chk("first_load_cd", int'(col_drive), 0);
    step(1);
    chk("row0_rd", int'(row_drive), 4'b0001);
    chk("row0_cd", int'(col_drive), 4'h1);
    step(4);
    chk("row1_load_idx", int'(row_index), 1);
    chk("row1_load_rd", int'(row_drive), 0);
    chk("row1_load_cd", int'(col_drive), 4'h1);
    step(1);
    chk("row1_rd", int'(row_drive), 4'b0010);
    chk("row1_cd", int'(col_drive), 4'h2);
    step(13);
    chk("wrap_fp", int'(frame_pulse), 1);
    chk("wrap_idx", int'(row_index), 3);
    chk("wrap_rd", int'(row_drive), 0);
    chk("wrap_cd", int'(col_drive), 4'h8);
    step(1);
    chk("after_wrap_fp", int'(frame_pulse), 0);
    chk("after_wrap_idx", int'(row_index), 0);
    step(1);
    chk("frame2_row0_cd", int'(col_drive), 4'h1);

    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (frame_pulse) pulses++;
    end
    chk("pulses_per_40", pulses, 2);

    // Drop enable in row 2, first SHOW cycle
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_p % 20 == 11) begin hit = 1'b1; break; end
      step(1);
    end
    chk("reach_row2_show", int'(hit), 1);
    chk("row2_show_rd", int'(row_drive), 4'b0100);
    en = 1'b0;
    step(1);
    chk("drop_rd", int'(row_drive), 0);
    chk("drop_idx", int'(row_index), 0);
    chk("drop_fp", int'(frame_pulse), 0);
    chk("drop_cd", int'(col_drive), 0);
    step(3);
    en = 1'b1;
    step(1);
    chk("reen_load_rd", int'(row_drive), 0);
    chk("reen_load_idx", int'(row_index), 0);
    step(1);
    chk("reen_row0_rd", int'(row_drive), 4'b0001);
    chk("reen_row0_cd", int'(col_drive), 4'h1);

    // Generation update mid-frame
    en = 1'b0;
    step(1);
    grid = 16'h000F;
    en = 1'b1;
    step(1);
    step(7);
    chk("gen_row1_cd", int'(col_drive), 4'h0);
    grid = 16'hFFFF;
    step(4);
`ifdef GRID_SCANNER_SNAPSHOT_EN
    chk("gen_row2_cd", int'(col_drive), 4'h0);
`else
    chk("gen_row2_cd", int'(col_drive), 4'hF);
`endif
    step(10);
    chk("gen_next_row0_cd", int'(col_drive), 4'hF);
    step(5);
    chk("gen_next_row1_cd", int'(col_drive), 4'hF);

    // Asynchronous reset mid-SHOW clears outputs without a clock edge
    step(1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rd", int'(row_drive), 0);
    chk("async_cd", int'(col_drive), 0);
    chk("async_idx", int'(row_index), 0);
    step(2);
    rst_n = 1'b1;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
